param_alu: RTL and testbench

PARAM_ALU -- requirements
Module: param_alu

---
 rtl/param_alu.sv | 263 ++++++++++++++++++++++++++
 tb/tb_param_alu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_alu.sv
// ----------------------------------------------------------------------------
// param_alu: parameterised multi-cycle integer ALU.
//
// Two operand registers (A, B) are loaded independently. A start pulse runs
// one operation on the registered operands. Add, subtract, logic and compare
// finish in one cycle. Multiply (shift-add) and divide (restoring) take one
// iteration per operand bit. The result and flag are registered and stay
// unchanged until the next done pulse.
//
// Parameters
//   WIDTH   operand width, 4..32
//
// Ports
//   clk     clock, all state updates on the rising edge
//   rst     asynchronous active-low reset
//   in_a    operand A data, captured when load_a is high and the ALU is idle
//   in_b    operand B data, captured when load_b is high and the ALU is idle
//   load_a  load strobe for register A
//   load_b  load strobe for register B
//   op      000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 CMP
//   start   run op on the current A/B; accepted only when idle
//   busy    operation in progress; start and loads are ignored
//   done    one-cycle pulse, result and flag are valid from this cycle on
//   result  2*WIDTH-bit result, held until the next done
//   flag    carry / borrow / overflow / divide-by-zero, held with result
// ----------------------------------------------------------------------------
module param_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               load_a,
  input  logic               load_b,
  input  logic [2:0]         op,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               flag
);

  localparam int unsigned RW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StIter = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMul = 3'b010;
  localparam logic [2:0] OpDiv = 3'b011;
  localparam logic [2:0] OpAnd = 3'b100;
  localparam logic [2:0] OpOr  = 3'b101;
  localparam logic [2:0] OpXor = 3'b110;
  localparam logic [2:0] OpCmp = 3'b111;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Snapshot of the operand that stays constant during iteration:
  // multiplicand for MUL, divisor for DIV.
  logic [WIDTH-1:0] opnd_q, opnd_d;
  // Iteration working register.
  //   MUL: {partial product high half, remaining multiplier bits}
  //   DIV: {partial remainder, dividend bits / quotient bits}
  logic [RW-1:0]    work_q, work_d;
  logic             is_div_q, is_div_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]    result_q, result_d;
  logic             flag_q, flag_d;

  logic             idle;
  assign idle = (state_q == StIdle);

  // --------------------------------------------------------------------------
  // Single-cycle datapath, fed from the pre-edge register values
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic             a_lt_b;
  logic             a_eq_b;

  assign add_sum  = {1'b0, a_q} + {1'b0, b_q};
  assign sub_diff = a_q - b_q;
  assign a_lt_b   = (a_q < b_q);
  assign a_eq_b   = (a_q == b_q);

  // --------------------------------------------------------------------------
  // Shift-add multiply step: add the multiplicand into the high half when the
  // current multiplier LSB is set, then shift the whole register right by one.
  // The carry of the add becomes the new MSB, so nothing is lost.
  // --------------------------------------------------------------------------
  logic [WIDTH:0] mul_sum;
  logic [RW-1:0]  mul_next;

  assign mul_sum  = {1'b0, work_q[RW-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

  // --------------------------------------------------------------------------
  // Restoring divide step: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits. The remainder after a successful
  // subtraction is always below the divisor, so modulo-2^WIDTH arithmetic on
  // the low bits gives the exact value.
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [WIDTH-1:0] div_rem;
  logic [RW-1:0]    div_next;

  assign div_shift = {work_q[RW-1:WIDTH], work_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_sub   = div_shift[WIDTH-1:0] - opnd_q;
  assign div_rem   = div_ge ? div_sub : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, work_q[WIDTH-2:0], div_ge};

  logic [RW-1:0] step_next;
  assign step_next = is_div_q ? div_next : mul_next;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    opnd_d   = opnd_q;
    work_d   = work_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flag_d   = flag_q;

    // Operand loads are only honoured while idle.
    if (idle) begin
      if (load_a) a_d = in_a;
      if (load_b) b_d = in_b;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StDone;
          unique case (op)
            OpAdd: begin
              result_d = {{(WIDTH-1){1'b0}}, add_sum};
              flag_d   = add_sum[WIDTH];
            end
            OpSub: begin
              result_d = {{WIDTH{1'b0}}, sub_diff};
              flag_d   = a_lt_b;
            end
            OpMul: begin
              state_d  = StIter;
              opnd_d   = a_q;
              work_d   = {{WIDTH{1'b0}}, b_q};
              is_div_d = 1'b0;
              cnt_d    = '0;
            end
            OpDiv: begin
              if (b_q == '0) begin
                result_d = {a_q, {WIDTH{1'b1}}};
                flag_d   = 1'b1;
              end else begin
                state_d  = StIter;
                opnd_d   = b_q;
                work_d   = {{WIDTH{1'b0}}, a_q};
                is_div_d = 1'b1;
                cnt_d    = '0;
              end
            end
            OpAnd: begin
              result_d = {{WIDTH{1'b0}}, a_q & b_q};
              flag_d   = 1'b0;
            end
            OpOr: begin
              result_d = {{WIDTH{1'b0}}, a_q | b_q};
              flag_d   = 1'b0;
            end
            OpXor: begin
              result_d = {{WIDTH{1'b0}}, a_q ^ b_q};
              flag_d   = 1'b0;
            end
            OpCmp: begin
              if (a_eq_b) begin
                result_d = '0;
              end else if (a_lt_b) begin
                result_d = {{(RW-2){1'b0}}, 2'd2};
              end else begin
                result_d = {{(RW-2){1'b0}}, 2'd1};
              end
              flag_d = a_eq_b;
            end
            default: ;
          endcase
        end
      end

      StIter: begin
        work_d = step_next;
        cnt_d  = cnt_q + CntW'(1);
        // Result and flag are only published as the FSM enters DONE, so the
        // previous result stays visible for the whole iteration.
        if (cnt_q == CntLast) begin
          state_d  = StDone;
          result_d = step_next;
          flag_d   = is_div_q ? 1'b0 : (step_next[RW-1:WIDTH] != '0);
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      opnd_q   <= '0;
      work_q   <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opnd_q   <= opnd_d;
      work_q   <= work_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy   = !idle;
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign flag   = flag_q;

endmodule

// File: tb/tb_param_alu.sv
// ----------------------------------------------------------------------------
// tb_param_alu: directed bench for param_alu. A WIDTH=8 instance runs a table
// of operations with hand-computed results; hand-written sequences cover the
// same-edge load/start case, ignored start/load while busy, reset in the
// middle of an iteration, and a WIDTH=16 instance.
// ----------------------------------------------------------------------------
module tb_param_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic [7:0]  a8, b8;
  logic        la8, lb8, st8;
  logic [2:0]  op8;
  logic        busy8, done8, flag8;
  logic [15:0] res8;

  // WIDTH=16 instance
  logic [15:0] a16, b16;
  logic        la16, lb16, st16;
  logic [2:0]  op16;
  logic        busy16, done16, flag16;
  logic [31:0] res16;

  param_alu #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .in_a   (a8),
    .in_b   (b8),
    .load_a (la8),
    .load_b (lb8),
    .op     (op8),
    .start  (st8),
    .busy   (busy8),
    .done   (done8),
    .result (res8),
    .flag   (flag8)
  );

  param_alu #(.WIDTH(16)) dut16 (
    .clk    (clk),
    .rst    (rst),
    .in_a   (a16),
    .in_b   (b16),
    .load_a (la16),
    .load_b (lb16),
    .op     (op16),
    .start  (st16),
    .busy   (busy16),
    .done   (done16),
    .result (res16),
    .flag   (flag16)
  );

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, DIV = 3'b011;
  localparam logic [2:0] AND = 3'b100, OR  = 3'b101, XOR = 3'b110, CMP = 3'b111;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        flag;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic do_load(input bit w16, input logic [15:0] a, input logic [15:0] b);
    if (w16) begin
      a16 = a; b16 = b; la16 = 1'b1; lb16 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; la8 = 1'b1; lb8 = 1'b1;
    end
    @(negedge clk);
    la8 = 1'b0; lb8 = 1'b0; la16 = 1'b0; lb16 = 1'b0;
  endtask

  task automatic start_op(input bit w16, input logic [2:0] op);
    if (w16) begin
      op16 = op; st16 = 1'b1;
    end else begin
      op8 = op; st8 = 1'b1;
    end
    @(negedge clk);
    st8 = 1'b0; st16 = 1'b0;
  endtask

  // lat0 is the number of negedges already seen since the start edge.
  task automatic wait_done(input bit w16, input int lat0, output int lat,
                           output logic [31:0] res, output logic flg);
    lat = lat0;
    while (!(w16 ? done16 : done8) && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    res = w16 ? res16 : {16'h0, res8};
    flg = w16 ? flag16 : flag8;
  endtask

  initial begin
    int          lat;
    logic [31:0] res;
    logic        flg;
    int          extra;

    a8 = '0; b8 = '0; la8 = 0; lb8 = 0; st8 = 0; op8 = '0;
    a16 = '0; b16 = '0; la16 = 0; lb16 = 0; st16 = 0; op16 = '0;

    vecs[0]  = '{ADD, 8'd200, 8'd100, 16'h012C, 1'b1, 1};
    vecs[1]  = '{SUB, 8'd2,   8'd7,   16'h00FB, 1'b1, 1};
    vecs[2]  = '{MUL, 8'd255, 8'd255, 16'hFE01, 1'b1, 9};
    vecs[3]  = '{DIV, 8'd15,  8'd3,   16'h0005, 1'b0, 9};
    vecs[4]  = '{DIV, 8'd20,  8'd0,   16'h14FF, 1'b1, 1};
    vecs[5]  = '{ADD, 8'd10,  8'd20,  16'h001E, 1'b0, 1};
    vecs[6]  = '{SUB, 8'd7,   8'd2,   16'h0005, 1'b0, 1};
    vecs[7]  = '{MUL, 8'd12,  8'd10,  16'h0078, 1'b0, 9};
    vecs[8]  = '{DIV, 8'd100, 8'd7,   16'h020E, 1'b0, 9};
    vecs[9]  = '{AND, 8'hF0,  8'h3C,  16'h0030, 1'b0, 1};
    vecs[10] = '{OR,  8'hF0,  8'h3C,  16'h00FC, 1'b0, 1};
    vecs[11] = '{XOR, 8'hF0,  8'h3C,  16'h00CC, 1'b0, 1};
    vecs[12] = '{CMP, 8'd5,   8'd5,   16'h0000, 1'b1, 1};
    vecs[13] = '{CMP, 8'd9,   8'd3,   16'h0001, 1'b0, 1};
    vecs[14] = '{CMP, 8'd3,   8'd9,   16'h0002, 1'b0, 1};
    vecs[15] = '{DIV, 8'd7,   8'd9,   16'h0700, 1'b0, 9};

    // Reset state
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'h0, busy8}, 32'h0);
    check("reset done", {31'h0, done8}, 32'h0);
    check("reset result", {16'h0, res8}, 32'h0);
    check("reset flag", {31'h0, flag8}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven operations on the 8-bit instance
    for (int i = 0; i < 16; i++) begin
      do_load(1'b0, {8'h0, vecs[i].a}, {8'h0, vecs[i].b});
      start_op(1'b0, vecs[i].op);
      wait_done(1'b0, 1, lat, res, flg);
      check($sformatf("vec%0d result", i), res, {16'h0, vecs[i].res});
      check($sformatf("vec%0d flag", i), {31'h0, flg}, {31'h0, vecs[i].flag});
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      @(negedge clk);
      check($sformatf("vec%0d done pulse", i), {31'h0, done8}, 32'h0);
    end

    // Load on the start edge: operation uses the old A, register takes the new
    do_load(1'b0, 16'd50, 16'd10);
    a8 = 8'd1; la8 = 1'b1; op8 = ADD; st8 = 1'b1;
    @(negedge clk);
    la8 = 1'b0; st8 = 1'b0;
    wait_done(1'b0, 1, lat, res, flg);
    check("same-edge result", res, 32'd60);
    @(negedge clk);
    start_op(1'b0, ADD);
    wait_done(1'b0, 1, lat, res, flg);
    check("same-edge new A", res, 32'd11);
    @(negedge clk);

    // Start and load_a while busy are dropped; result held through ITER
    do_load(1'b0, 16'd6, 16'd7);
    start_op(1'b0, MUL);
    repeat (2) @(negedge clk);
    check("held during iter", {16'h0, res8}, 32'd11);
    check("busy during iter", {31'h0, busy8}, 32'h1);
    a8 = 8'h55; la8 = 1'b1; op8 = ADD; st8 = 1'b1;
    @(negedge clk);
    la8 = 1'b0; st8 = 1'b0;
    wait_done(1'b0, 4, lat, res, flg);
    check("busy-ignore result", res, 32'd42);
    check("busy-ignore latency", lat, 9);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) extra++;
    end
    check("busy-ignore no second done", extra, 0);
    b8 = 8'd1; lb8 = 1'b1;
    @(negedge clk);
    lb8 = 1'b0;
    start_op(1'b0, ADD);
    wait_done(1'b0, 1, lat, res, flg);
    check("busy-ignore A unchanged", res, 32'd7);
    @(negedge clk);

    // Reset in the middle of ITER
    do_load(1'b0, 16'd9, 16'd9);
    start_op(1'b0, MUL);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid-iter rst busy", {31'h0, busy8}, 32'h0);
    check("mid-iter rst done", {31'h0, done8}, 32'h0);
    check("mid-iter rst result", {16'h0, res8}, 32'h0);
    check("mid-iter rst flag", {31'h0, flag8}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) extra++;
    end
    check("mid-iter rst no done", extra, 0);
    // Registers were cleared: 0 + 0
    op8 = CMP; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    wait_done(1'b0, 1, lat, res, flg);
    check("post-rst cmp result", res, 32'd0);
    check("post-rst cmp flag", {31'h0, flg}, 32'h1);
    @(negedge clk);
    do_load(1'b0, 16'd13, 16'd11);
    start_op(1'b0, MUL);
    wait_done(1'b0, 1, lat, res, flg);
    check("post-rst mul result", res, 32'h008F);
    check("post-rst mul latency", lat, 9);
    @(negedge clk);

    // WIDTH=16 instance
    do_load(1'b1, 16'hFFFF, 16'h0002);
    start_op(1'b1, MUL);
    wait_done(1'b1, 1, lat, res, flg);
    check("w16 mul result", res, 32'h0001FFFE);
    check("w16 mul flag", {31'h0, flg}, 32'h1);
    check("w16 mul latency", lat, 17);
    @(negedge clk);
    do_load(1'b1, 16'd3, 16'd9);
    start_op(1'b1, CMP);
    wait_done(1'b1, 1, lat, res, flg);
    check("w16 cmp result", res, 32'd2);
    check("w16 cmp flag", {31'h0, flg}, 32'h0);
    check("w16 cmp latency", lat, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
